// File: rtl/masked_and_sched.sv
// rtl/masked_and_sched.sv - round-robin scheduler for a shared two-share masked AND gadget
// Optional RNG freshness check: define MASKED_AND_SCHED_RNG_CHECK_EN
module masked_and_sched #(
    parameter int N    = 32,
    parameter int NREQ = 2
) (
    input  logic                g_clk,
    input  logic                g_rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_ax,
    input  logic [NREQ*N-1:0]   req_ay,
    input  logic [NREQ*N-1:0]   req_bx,
    input  logic [NREQ*N-1:0]   req_by,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [N-1:0]        rsp_qx,
    output logic [N-1:0]        rsp_qy,
    input  logic                rng_valid,
    output logic                rng_ready,
    input  logic [2*N-1:0]      rng_data,
    output logic                gd_clk_en,
    output logic [N-1:0]        gd_z0,
    output logic [N-1:0]        gd_z1,
    output logic [N-1:0]        gd_ax,
    output logic [N-1:0]        gd_ay,
    output logic [N-1:0]        gd_bx,
    output logic [N-1:0]        gd_by,
    input  logic [N-1:0]        gd_qx,
    input  logic [N-1:0]        gd_qy,
    output logic                busy,
    output logic                err_rng
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CAPT  = 3'd1,
        ISSUE = 3'd2,
        EVAL  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t          state;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   gnt_idx;
    logic [N-1:0]    op_ax, op_ay, op_bx, op_by;
    logic [N-1:0]    z0_q, z1_q;
    logic [N-1:0]    res_qx, res_qy;
    logic            clk_en_q;
    logic            busy_q;
    logic [NREQ-1:0] rsp_valid_q;

    logic            any_req;
    logic            found;
    logic [GW-1:0]   win;
    logic [GW:0]     win_sum;
    logic [GW-1:0]   rr_next;
    logic [NREQ-1:0] win_onehot;
    logic [NREQ-1:0] gnt_onehot;
    logic [N-1:0]    sel_ax, sel_ay, sel_bx, sel_by;
    logic            rng_bad;
    logic            grant_ok;
    logic            drop_word;

    assign any_req = |req_valid;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping around
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_sum = {1'b0, rr_ptr} + (GW+1)'(i);
            if (win_sum >= (GW+1)'(NREQ)) begin
                win_sum = win_sum - (GW+1)'(NREQ);
            end
            if (!found && req_valid[win_sum[GW-1:0]]) begin
                found = 1'b1;
                win   = win_sum[GW-1:0];
            end
        end
        rr_next = (win == GW'(NREQ-1)) ? '0 : win + 1'b1;
    end

    // Operand mux and one-hot decodes of the winner and stored grant
    always_comb begin
        sel_ax     = '0;
        sel_ay     = '0;
        sel_bx     = '0;
        sel_by     = '0;
        win_onehot = '0;
        gnt_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == GW'(i)) begin
                sel_ax        = req_ax[i*N +: N];
                sel_ay        = req_ay[i*N +: N];
                sel_bx        = req_bx[i*N +: N];
                sel_by        = req_by[i*N +: N];
                win_onehot[i] = 1'b1;
            end
            if (gnt_idx == GW'(i)) begin
                gnt_onehot[i] = 1'b1;
            end
        end
    end

`ifdef MASKED_AND_SCHED_RNG_CHECK_EN
    logic [2*N-1:0] prev_rng;
    logic           err_q;

    assign rng_bad = (rng_data == prev_rng) || (rng_data == '0);
    assign err_rng = err_q;

    // Track the last consumed word and flag stale or zero randomness (sticky until reset)
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            prev_rng <= '0;
            err_q    <= 1'b0;
        end else begin
            if (grant_ok) begin
                prev_rng <= rng_data;
            end
            if (drop_word) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign rng_bad = 1'b0;
    assign err_rng = 1'b0;
`endif

    // Handshakes are same-cycle, so they are decoded from the registered state
    assign grant_ok  = (state == IDLE) && any_req && rng_valid && !rng_bad;
    assign drop_word = (state == IDLE) && any_req && rng_valid && rng_bad;
    assign req_ready = grant_ok ? win_onehot : '0;
    assign rng_ready = grant_ok | drop_word;

    assign gd_clk_en = clk_en_q;
    assign gd_ax     = op_ax;
    assign gd_ay     = op_ay;
    assign gd_bx     = op_bx;
    assign gd_by     = op_by;
    assign gd_z0     = z0_q;
    assign gd_z1     = z1_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_qx    = res_qx;
    assign rsp_qy    = res_qy;
    assign busy      = busy_q;

    // Main sequencer: capture, issue to gadget, evaluate, return result; clears secrets as it goes
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            op_ax       <= '0;
            op_ay       <= '0;
            op_bx       <= '0;
            op_by       <= '0;
            z0_q        <= '0;
            z1_q        <= '0;
            res_qx      <= '0;
            res_qy      <= '0;
            clk_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        op_ax   <= sel_ax;
                        op_ay   <= sel_ay;
                        op_bx   <= sel_bx;
                        op_by   <= sel_by;
                        z0_q    <= rng_data[N-1:0];
                        z1_q    <= rng_data[2*N-1:N];
                        gnt_idx <= win;
                        rr_ptr  <= rr_next;
                        busy_q  <= 1'b1;
                        state   <= CAPT;
                    end
                end
                CAPT: begin
                    clk_en_q <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    clk_en_q <= 1'b0;
                    z0_q     <= '0;
                    z1_q     <= '0;
                    state    <= EVAL;
                end
                EVAL: begin
                    res_qx      <= gd_qx;
                    res_qy      <= gd_qy;
                    op_ax       <= '0;
                    op_ay       <= '0;
                    op_bx       <= '0;
                    op_by       <= '0;
                    rsp_valid_q <= gnt_onehot;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_idx]) begin
                        res_qx      <= '0;
                        res_qy      <= '0;
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_and_sched.sv
// tb/tb_masked_and_sched.sv - directed self-checking bench for masked_and_sched
module tb_masked_and_sched;

    localparam int N    = 8;
    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              g_rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_ax, req_ay, req_bx, req_by;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [N-1:0]      rsp_qx, rsp_qy;
    logic              rng_valid;
    logic              rng_ready;
    logic [2*N-1:0]    rng_data;
    logic              gd_clk_en;
    logic [N-1:0]      gd_z0, gd_z1, gd_ax, gd_ay, gd_bx, gd_by;
    logic [N-1:0]      gd_qx, gd_qy;
    logic              busy;
    logic              err_rng;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    masked_and_sched #(.N(N), .NREQ(NREQ)) dut (
        .g_clk     (clk),
        .g_rst     (g_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ax    (req_ax),
        .req_ay    (req_ay),
        .req_bx    (req_bx),
        .req_by    (req_by),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_qx    (rsp_qx),
        .rsp_qy    (rsp_qy),
        .rng_valid (rng_valid),
        .rng_ready (rng_ready),
        .rng_data  (rng_data),
        .gd_clk_en (gd_clk_en),
        .gd_z0     (gd_z0),
        .gd_z1     (gd_z1),
        .gd_ax     (gd_ax),
        .gd_ay     (gd_ay),
        .gd_bx     (gd_bx),
        .gd_by     (gd_by),
        .gd_qx     (gd_qx),
        .gd_qy     (gd_qy),
        .busy      (busy),
        .err_rng   (err_rng)
    );

    // Gadget model: cross terms registered under clk_en, inner terms combinational
    logic [N-1:0] g_r0 = '0;
    logic [N-1:0] g_r1 = '0;
    always @(posedge clk) begin
        if (gd_clk_en) begin
            g_r0 <= (gd_ax & gd_by) ^ gd_z0 ^ gd_z1;
            g_r1 <= (gd_bx & gd_ay) ^ gd_z0 ^ gd_z1;
        end
    end
    assign gd_qx = (gd_ax & gd_ay) ^ g_r0;
    assign gd_qy = (gd_bx & gd_by) ^ g_r1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE with inputs driven; leaves the DUT in RESP
    task automatic run_op(input string tag, input logic [1:0] exp_gnt, input logic [7:0] exp_q);
        chk({tag, "_req_ready"}, {30'd0, req_ready}, {30'd0, exp_gnt});
        chk({tag, "_rng_ready"}, {31'd0, rng_ready}, 32'd1);
        tick;
        chk({tag, "_capt_clk_en"}, {31'd0, gd_clk_en}, 32'd0);
        tick;
        chk({tag, "_issue_clk_en"}, {31'd0, gd_clk_en}, 32'd1);
        tick;
        chk({tag, "_eval_clk_en"}, {31'd0, gd_clk_en}, 32'd0);
        chk({tag, "_eval_z0"}, {24'd0, gd_z0}, 32'd0);
        tick;
        chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, {30'd0, exp_gnt});
        chk({tag, "_result"}, {24'd0, rsp_qx ^ rsp_qy}, {24'd0, exp_q});
        chk({tag, "_resp_gd_ax"}, {24'd0, gd_ax}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        g_rst     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        rng_valid = 1'b0;
        rng_data  = '0;
        // requester 0: x=5A^3C=66, y=0F^F0=FF -> 66 ; requester 1: x=FF^0F=F0, y=33^00=33 -> 30
        req_ax = {8'hFF, 8'h5A};
        req_bx = {8'h0F, 8'h3C};
        req_ay = {8'h33, 8'h0F};
        req_by = {8'h00, 8'hF0};
        tick;
        tick;
        g_rst = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rng_ready", {31'd0, rng_ready}, 32'd0);
        chk("rst_clk_en", {31'd0, gd_clk_en}, 32'd0);
        chk("rst_gd_ax", {24'd0, gd_ax}, 32'd0);
        chk("rst_err_rng", {31'd0, err_rng}, 32'd0);

        // Single op, requester 0, with operand/randomness visibility in CAPT
        req_valid = 2'b01;
        rng_valid = 1'b1;
        rng_data  = 16'hA5C3;
        rsp_ready = 2'b01;
        #1;
        chk("single_req_ready", {30'd0, req_ready}, 32'd1);
        tick;
        req_valid = 2'b00;
        rng_valid = 1'b0;
        #1;
        chk("single_busy", {31'd0, busy}, 32'd1);
        chk("single_gd_ax", {24'd0, gd_ax}, 32'h5A);
        chk("single_gd_by", {24'd0, gd_by}, 32'hF0);
        chk("single_gd_z0", {24'd0, gd_z0}, 32'hC3);
        chk("single_gd_z1", {24'd0, gd_z1}, 32'hA5);
        chk("single_capt_en", {31'd0, gd_clk_en}, 32'd0);
        tick;
        chk("single_issue_en", {31'd0, gd_clk_en}, 32'd1);
        tick;
        chk("single_eval_en", {31'd0, gd_clk_en}, 32'd0);
        chk("single_eval_rsp", {30'd0, rsp_valid}, 32'd0);
        tick;
        chk("single_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("single_result", {24'd0, rsp_qx ^ rsp_qy}, 32'h66);
        tick;
        chk("single_done_busy", {31'd0, busy}, 32'd0);
        chk("single_done_rsp", {30'd0, rsp_valid}, 32'd0);
        chk("single_done_qx", {24'd0, rsp_qx}, 32'd0);

        // Both requesters continuously valid from reset: grants alternate 0,1,0,1
        g_rst = 1'b1;
        tick;
        g_rst     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        rng_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rng_data = {8'h10 + 8'(i), 8'h81 + 8'(i)};
            #1;
            if (i % 2 == 0) run_op("alt_even", 2'b01, 8'h66);
            else            run_op("alt_odd", 2'b10, 8'h30);
            tick;
        end

        // RNG starvation: no grant, not busy, until rng_valid rises
        req_valid = 2'b10;
        rng_valid = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("starve_req_ready", {30'd0, req_ready}, 32'd0);
            chk("starve_busy", {31'd0, busy}, 32'd0);
            chk("starve_rng_ready", {31'd0, rng_ready}, 32'd0);
            tick;
        end
        rng_valid = 1'b1;
        rng_data  = 16'h5577;
        #1;
        run_op("starve", 2'b10, 8'h30);
        tick;

        // Backpressure on requester 0; rsp_ready of requester 1 is ignored
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        rng_data  = 16'h6688;
        #1;
        run_op("bp", 2'b01, 8'h66);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
            chk("bp_result", {24'd0, rsp_qx ^ rsp_qy}, 32'h66);
            chk("bp_no_grant", {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = 2'b01;
        tick;
        chk("bp_done_rsp", {30'd0, rsp_valid}, 32'd0);
        chk("bp_done_busy", {31'd0, busy}, 32'd0);
        req_valid = 2'b00;

        // Reset during ISSUE aborts the op, then a fresh op completes normally
        req_valid = 2'b01;
        rng_data  = 16'h7799;
        #1;
        chk("abort_req_ready", {30'd0, req_ready}, 32'd1);
        tick;
        req_valid = 2'b00;
        tick;
        chk("abort_issue_en", {31'd0, gd_clk_en}, 32'd1);
        g_rst = 1'b1;
        tick;
        g_rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_clk_en", {31'd0, gd_clk_en}, 32'd0);
        chk("abort_gd_ax", {24'd0, gd_ax}, 32'd0);
        chk("abort_gd_z0", {24'd0, gd_z0}, 32'd0);
        chk("abort_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("abort_req_ready", {30'd0, req_ready}, 32'd0);
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        rng_data  = 16'h8899;
        #1;
        run_op("after_abort", 2'b10, 8'h30);
        tick;

        // Repeated randomness word
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        rng_data  = 16'h1234;
        #1;
        run_op("fresh1", 2'b01, 8'h66);
        tick;
`ifdef MASKED_AND_SCHED_RNG_CHECK_EN
        #1;
        chk("stale_req_ready", {30'd0, req_ready}, 32'd0);
        chk("stale_rng_ready", {31'd0, rng_ready}, 32'd1);
        tick;
        chk("stale_err_rng", {31'd0, err_rng}, 32'd1);
        chk("stale_busy", {31'd0, busy}, 32'd0);
        rng_data = 16'h4321;
        #1;
        run_op("fresh2", 2'b01, 8'h66);
        tick;
        chk("sticky_err_rng", {31'd0, err_rng}, 32'd1);
`else
        #1;
        chk("nocheck_err_rng", {31'd0, err_rng}, 32'd0);
        run_op("repeat", 2'b01, 8'h66);
        tick;
`endif
        req_valid = 2'b00;
        rng_valid = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
